seg7_pattern_decoder: RTL and testbench

Receive-side counterpart of the 8-3 priority encoder's display path. It samples an 8-bit active-low seven-segment pattern bus (HEX format: bit7..bit1 = segments a..g, bit0 = dp) and waits until the pattern has been stable for a programmable number of clock edges. It then decodes the pattern back into the encoder's native signals: BCD code, one-hot line vector, valid and enable. It sits at the display-to-logic boundary, for example for loop-back self-check of encoder boards, and it filters transient glitches while counting illegal patterns.

---
 rtl/seg7_pattern_decoder.sv | 172 +++++++++++++++++
 tb/tb_seg7_pattern_decoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seg7_pattern_decoder.sv
// Decodes a debounced active-low seven-segment pattern back into BCD, one-hot,
// valid and enable signals, with glitch filtering and a saturating illegal-pattern count.
module seg7_pattern_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hex,
    output logic [7:0] x,
    output logic [3:0] y,
    output logic       p,
    output logic       en,
    output logic       err,
    output logic       upd,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        S_BLANK   = 2'd0,
        S_DIGIT   = 2'd1,
        S_ILLEGAL = 2'd2
    } state_t;

    localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

    // Returns {legal_digit, digit}; dp must be high (off) for a legal digit.
    function automatic logic [4:0] seg_lookup(input logic [7:0] pat);
        logic [4:0] res;
        case (pat)
            8'h03:   res = 5'b1_0000;
            8'h9F:   res = 5'b1_0001;
            8'h25:   res = 5'b1_0010;
            8'h0D:   res = 5'b1_0011;
            8'h99:   res = 5'b1_0100;
            8'h49:   res = 5'b1_0101;
            8'h41:   res = 5'b1_0110;
            8'h1F:   res = 5'b1_0111;
            8'h01:   res = 5'b1_1000;
            8'h09:   res = 5'b1_1001;
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

    state_t     r_state;
    state_t     w_state_next;
    state_t     w_class;
    logic [7:0] r_samp;
    logic [3:0] r_run;
    logic [7:0] r_committed;
    logic [7:0] r_x;
    logic [3:0] r_y;
    logic       r_p;
    logic       r_en;
    logic       r_err;
    logic       r_upd;
    logic [7:0] r_err_cnt;

    logic [4:0] w_lut;
    logic [3:0] w_run_next;
    logic       w_commit;
    logic [7:0] w_x_next;
    logic [3:0] w_y_next;
    logic       w_p_next;
    logic       w_en_next;
    logic       w_err_next;

    always_comb begin
        w_lut        = seg_lookup(hex);
        w_run_next   = 4'd1;
        w_commit     = 1'b0;
        w_class      = S_ILLEGAL;
        w_state_next = r_state;
        w_x_next     = 8'h00;
        w_y_next     = 4'd0;
        w_p_next     = 1'b0;
        w_en_next    = 1'b0;
        w_err_next   = 1'b0;

        if (hex == r_samp) begin
            w_run_next = (r_run >= STABLE_N) ? STABLE_N : (r_run + 4'd1);
        end else begin
            w_run_next = 4'd1;
        end
        w_commit = (w_run_next == STABLE_N) && (hex != r_committed);

        if (hex == 8'hFF) begin
            w_class = S_BLANK;
        end else if (w_lut[4]) begin
            w_class = S_DIGIT;
        end else begin
            w_class = S_ILLEGAL;
        end

        // Output image of the incoming pattern; only loaded on a commit.
        case (w_class)
            S_BLANK: begin
                w_en_next = 1'b0;
            end
            S_DIGIT: begin
                w_en_next = 1'b1;
                w_p_next  = 1'b1;
                w_y_next  = w_lut[3:0];
                if (w_lut[3] == 1'b0) begin
                    w_x_next = 8'b0000_0001 << w_lut[2:0];
                end else begin
                    w_x_next = 8'h00;
                end
            end
            S_ILLEGAL: begin
                w_en_next  = 1'b1;
                w_err_next = 1'b1;
            end
            default: begin
                w_en_next = 1'b0;
            end
        endcase

        if (w_commit) begin
            w_state_next = w_class;
        end else begin
            w_state_next = r_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samp      <= 8'hFF;
            r_run       <= 4'd0;
            r_committed <= 8'hFF;
            r_x         <= 8'h00;
            r_y         <= 4'd0;
            r_p         <= 1'b0;
            r_en        <= 1'b0;
            r_err       <= 1'b0;
            r_upd       <= 1'b0;
            r_err_cnt   <= 8'h00;
        end else begin
            r_samp <= hex;
            r_run  <= w_run_next;
            r_upd  <= w_commit;
            if (w_commit) begin
                r_committed <= hex;
                r_x         <= w_x_next;
                r_y         <= w_y_next;
                r_p         <= w_p_next;
                r_en        <= w_en_next;
                r_err       <= w_err_next;
                if ((w_class == S_ILLEGAL) && (r_err_cnt != 8'hFF)) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    assign x       = r_x;
    assign y       = r_y;
    assign p       = r_p;
    assign en      = r_en;
    assign err     = r_err;
    assign upd     = r_upd;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Directed table-driven bench for seg7_pattern_decoder at STABLE_CYCLES=4 and =1.
module tb_seg7_pattern_decoder;

    typedef struct {
        logic [7:0] hex;
        logic [3:0] y;
        logic [7:0] x;
        logic       p;
        logic       en;
        logic       err;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] hex4, hex1;
    logic [7:0] x4, x1;
    logic [3:0] y4, y1;
    logic       p4, en4, err4, upd4;
    logic       p1, en1, err1, upd1;
    logic [7:0] ec4, ec1;

    int         n_checks;
    int         n_errors;
    logic [7:0] exp_ec;
    vec_t       cur;
    vec_t       tbl [12];
    vec_t       blank_v;
    vec_t       ill_v;

    seg7_pattern_decoder #(.STABLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .hex(hex4), .x(x4), .y(y4), .p(p4),
        .en(en4), .err(err4), .upd(upd4), .err_cnt(ec4)
    );

    seg7_pattern_decoder #(.STABLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .hex(hex1), .x(x1), .y(y1), .p(p1),
        .en(en1), .err(err1), .upd(upd1), .err_cnt(ec1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mk(input vec_t v, input logic u, input logic [7:0] ec);
        return {v.y, v.x, v.p, v.en, v.err, u, ec};
    endfunction

    function automatic logic [23:0] obs4();
        return {y4, x4, p4, en4, err4, upd4, ec4};
    endfunction

    function automatic logic [23:0] obs1();
        return {y1, x1, p1, en1, err1, upd1, ec1};
    endfunction

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h ({y,x,p,en,err,upd,err_cnt})", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds pat on the STABLE_CYCLES=4 instance; a commit is expected on the 4th edge
    // only if pat differs from the currently committed pattern.
    task automatic hold(input string nm, input logic [7:0] pat, input vec_t target, input int cycles);
        vec_t t;
        t     = target;
        t.hex = pat;
        hex4  = pat;
        for (int c = 1; c <= cycles; c++) begin
            step();
            if ((c == 4) && (pat != cur.hex)) begin
                cur = t;
                if (t.err && (exp_ec != 8'hFF)) exp_ec = exp_ec + 8'd1;
                chk(nm, obs4(), mk(cur, 1'b1, exp_ec));
            end else begin
                chk(nm, obs4(), mk(cur, 1'b0, exp_ec));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_ec   = 8'h00;
        blank_v  = '{8'hFF, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        ill_v    = '{8'h55, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1};
        cur      = blank_v;
        tbl[0]   = '{8'h03, 4'd0, 8'h01, 1'b1, 1'b1, 1'b0};
        tbl[1]   = '{8'h9F, 4'd1, 8'h02, 1'b1, 1'b1, 1'b0};
        tbl[2]   = '{8'h25, 4'd2, 8'h04, 1'b1, 1'b1, 1'b0};
        tbl[3]   = '{8'h0D, 4'd3, 8'h08, 1'b1, 1'b1, 1'b0};
        tbl[4]   = '{8'h99, 4'd4, 8'h10, 1'b1, 1'b1, 1'b0};
        tbl[5]   = '{8'h49, 4'd5, 8'h20, 1'b1, 1'b1, 1'b0};
        tbl[6]   = '{8'h41, 4'd6, 8'h40, 1'b1, 1'b1, 1'b0};
        tbl[7]   = '{8'h1F, 4'd7, 8'h80, 1'b1, 1'b1, 1'b0};
        tbl[8]   = '{8'h01, 4'd8, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[9]   = '{8'h09, 4'd9, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[10]  = '{8'h02, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[11]  = '{8'hFF, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0};

        rst  = 1'b1;
        hex4 = 8'hFF;
        hex1 = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        chk("reset4", obs4(), mk(blank_v, 1'b0, 8'h00));
        chk("reset1", obs1(), mk(blank_v, 1'b0, 8'h00));
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            step();
            chk("idle_blank4", obs4(), mk(blank_v, 1'b0, 8'h00));
            chk("idle_blank1", obs1(), mk(blank_v, 1'b0, 8'h00));
        end

        for (int i = 0; i < 12; i++) begin
            hold($sformatf("table_%0d", i), tbl[i].hex, tbl[i], 6);
        end

        hold("commit5", 8'h49, tbl[5], 6);
        hold("glitch25", 8'h25, tbl[2], 3);
        hold("restore5", 8'h49, tbl[5], 6);

        hold("illegal55", 8'h55, ill_v, 4);
        for (int i = 0; i < 300; i++) begin
            hold("sat_AA", 8'hAA, ill_v, 4);
            hold("sat_55", 8'h55, ill_v, 4);
        end
        chk("err_cnt_sat", {16'h0000, ec4}, 24'h0000FF);

        hold("pre_rst_1F", 8'h1F, tbl[7], 2);
        rst = 1'b1;
        #1;
        cur    = blank_v;
        exp_ec = 8'h00;
        chk("async_reset", obs4(), mk(blank_v, 1'b0, 8'h00));
        rst = 1'b0;
        hold("post_rst_1F", 8'h1F, tbl[7], 6);

        hex1 = 8'h03;
        step();
        chk("s1_03", obs1(), mk(tbl[0], 1'b1, 8'h00));
        hex1 = 8'h9F;
        step();
        chk("s1_9F", obs1(), mk(tbl[1], 1'b1, 8'h00));
        hex1 = 8'hFF;
        step();
        chk("s1_FF", obs1(), mk(blank_v, 1'b1, 8'h00));
        step();
        chk("s1_hold", obs1(), mk(blank_v, 1'b0, 8'h00));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
